// File: rtl/upscale.sv
// rtl/upscale.sv - saturating left-shift expansion of signed pixels to number width
// Elastic two-stage pipeline with a sticky saturation event counter.
module upscale #(
  parameter int IMG_WIDTH = 16,
  parameter int NUM_WIDTH = 33,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           shift,
  input  logic [IMG_WIDTH-1:0] up_data,
  input  logic                 up_valid,
  output logic                 up_ready,
  output logic [NUM_WIDTH-1:0] dn_data,
  output logic                 dn_sat,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  input  logic                 sat_clear,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam logic [NUM_WIDTH-1:0] NUM_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
  localparam logic [NUM_WIDTH-1:0] NUM_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

  logic                        p1_valid;
  logic signed [NUM_WIDTH-1:0] p1_data;
  logic [7:0]                  p1_shift;
  logic                        p1_load;
  logic                        p2_load;

  logic signed [NUM_WIDTH-1:0] shifted;
  logic signed [NUM_WIDTH-1:0] restored;
  logic [NUM_WIDTH-1:0]        res_data;
  logic                        res_sat;

  assign p2_load  = ~dn_valid | dn_ready;
  assign p1_load  = ~p1_valid | p2_load;
  // Held high throughout reset so upstream never sees a stall while the pipe is flushed
  assign up_ready = p1_load | ~rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_data  <= '0;
      p1_shift <= '0;
    end else if (p1_load) begin
      p1_valid <= up_valid;
      if (up_valid) begin
        p1_data  <= {{(NUM_WIDTH-IMG_WIDTH){up_data[IMG_WIDTH-1]}}, up_data};
        p1_shift <= shift;
      end
    end
  end

  // A shift fits iff shifting back recovers the operand: that holds exactly when the
  // pushed-out bits and the new MSB all match the sign. Shifts >= NUM_WIDTH yield 0,
  // so any nonzero operand then saturates while zero passes through as zero.
  always_comb begin
    shifted  = p1_data <<< p1_shift;
    restored = shifted >>> p1_shift;
    res_data = shifted;
    res_sat  = 1'b0;
    if (restored != p1_data) begin
      res_sat  = 1'b1;
      res_data = p1_data[NUM_WIDTH-1] ? NUM_MIN : NUM_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_sat   <= 1'b0;
    end else if (p2_load) begin
      dn_valid <= p1_valid;
      if (p1_valid) begin
        dn_data <= res_data;
        dn_sat  <= res_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (dn_valid && dn_ready && dn_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_upscale.sv
// tb/tb_upscale.sv - self-checking bench for upscale against an arithmetic model
// Directed vectors plus a per-cycle compare of every output against a queue model.
module tb_upscale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  shift;
  logic [15:0] up_data;
  logic        up_valid;
  logic        up_ready;
  logic [32:0] dn_data;
  logic        dn_sat;
  logic        dn_valid;
  logic        dn_ready;
  logic        sat_clear;
  logic [15:0] sat_count;

  upscale #(.IMG_WIDTH(16), .NUM_WIDTH(33), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .shift(shift), .up_data(up_data),
    .up_valid(up_valid), .up_ready(up_ready), .dn_data(dn_data),
    .dn_sat(dn_sat), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .sat_clear(sat_clear), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] d;
    logic        s;
    int          tag;
  } ent_t;

  ent_t        q[$];
  logic [32:0] out_d[$];
  logic        out_s[$];
  int          out_e[$];
  int          acc_e[$];
  int          k = 0;
  int          model_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // V = d * 2^s evaluated in 64-bit integers, then clamped to the 33-bit signed range
  function automatic ent_t model(input logic [15:0] d, input logic [7:0] s);
    ent_t   e;
    longint dv, v;
    longint nmax = (longint'(1) << 32) - 1;
    longint nmin = -(longint'(1) << 32);
    dv = longint'($signed(d));
    e.tag = 0;
    e.s   = 1'b0;
    if (dv == 0) begin
      e.d = '0;
    end else if (s >= 8'd40) begin
      e.s = 1'b1;
      v   = (dv > 0) ? nmax : nmin;
      e.d = v[32:0];
    end else begin
      v = dv * (longint'(1) << s);
      if (v > nmax) begin
        v = nmax; e.s = 1'b1;
      end else if (v < nmin) begin
        v = nmin; e.s = 1'b1;
      end
      e.d = v[32:0];
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dn_ready = 1'b1;
      1:       dn_ready = 1'($urandom_range(0, 1));
      default: dn_ready = 1'b0;
    endcase
  end

  // Compare process: inputs change only just after posedges, so values seen here are
  // exactly those the next posedge acts on.
  always @(negedge clk) begin
    ent_t e;
    logic exp_v;
    k++;
    chk("sat_count", 64'(sat_count), 64'(model_cnt));
    if (rst_n === 1'b1) begin
      exp_v = (q.size() > 0) && (q[0].tag < k);
      chk("dn_valid", 64'(dn_valid), 64'(exp_v));
      if (dn_valid && exp_v) begin
        chk("dn_data", 64'(dn_data), 64'(q[0].d));
        chk("dn_sat", 64'(dn_sat), 64'(q[0].s));
      end
      chk("up_ready", 64'(up_ready), 64'(!(q.size() == 2 && !dn_ready)));
    end else begin
      chk("up_ready_rst", 64'(up_ready), 64'd1);
    end

    if (rst_n !== 1'b1) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (dn_valid && dn_ready && q.size() > 0) begin
        if (sat_clear) model_cnt = 0;
        else if (q[0].s && model_cnt != 16'hFFFF) model_cnt++;
        out_d.push_back(dn_data);
        out_s.push_back(dn_sat);
        out_e.push_back(k + 1);
        void'(q.pop_front());
      end else if (sat_clear) begin
        model_cnt = 0;
      end
      if (up_valid && up_ready) begin
        e = model(up_data, shift);
        e.tag = k + 1;
        q.push_back(e);
        acc_e.push_back(k + 1);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] s);
    int tries;
    up_data  = d;
    shift    = s;
    up_valid = 1'b1;
    tries    = 0;
    @(negedge clk);
    while (!up_ready && tries < 200) begin
      tries++;
      @(negedge clk);
    end
    if (tries >= 200) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [7:0]  s;
    logic [32:0] r;
    logic        sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base, abase;
    rst_n = 1'b0; up_valid = 1'b0; up_data = '0; shift = '0;
    sat_clear = 1'b0; dn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_dn_data", 64'(dn_data), 64'd0);
    chk("rst_dn_sat", 64'(dn_sat), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{16'h8000, 8'd0,   33'h1_FFFF_8000, 1'b0};
    vecs[1] = '{16'h7FFF, 8'd0,   33'h0_0000_7FFF, 1'b0};
    vecs[2] = '{16'h7FFF, 8'd17,  33'h0_FFFE_0000, 1'b0};
    vecs[3] = '{16'h7FFF, 8'd18,  33'h0_FFFF_FFFF, 1'b1};
    vecs[4] = '{16'h8000, 8'd17,  33'h1_0000_0000, 1'b0};
    vecs[5] = '{16'hFFFF, 8'd32,  33'h1_0000_0000, 1'b0};
    vecs[6] = '{16'hFFFF, 8'd33,  33'h1_0000_0000, 1'b1};
    vecs[7] = '{16'h0000, 8'd255, 33'h0,           1'b0};

    base  = out_d.size();
    abase = acc_e.size();
    for (int i = 0; i < 8; i++) send(vecs[i].d, vecs[i].s);
    drain();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_data", i), 64'(out_d[base+i]), 64'(vecs[i].r));
      chk($sformatf("vec%0d_sat", i), 64'(out_s[base+i]), 64'(vecs[i].sat));
    end
    chk("pass_latency", 64'(out_e[base] - acc_e[abase]), 64'd2);

    rdy_mode = 1;
    base = out_d.size();
    for (int i = 1; i <= 10; i++) send(16'(i), 8'd4);
    drain();
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      chk($sformatf("bp%0d", i), 64'(out_d[base+i]), 64'(16 * (i + 1)));

    base  = out_d.size();
    abase = acc_e.size();
    for (int i = 0; i < 100; i++) send(16'(i * 3 - 50), 8'd1);
    drain();
    chk("full_rate_span", 64'(out_e[base+99] - out_e[base]), 64'd99);
    chk("full_rate_fill", 64'(out_e[base] - acc_e[abase]), 64'd2);

    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    send(16'h7FFF, 8'd20);
    send(16'h0001, 8'd1);
    send(16'h8000, 8'd20);
    send(16'h0000, 8'd200);
    send(16'h0001, 8'd40);
    drain();
    chk("cnt_three", 64'(sat_count), 64'd3);
    send(16'hC000, 8'd30);
    @(posedge clk); #1;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("cnt_clear_coincident", 64'(sat_count), 64'd0);
    chk("cnt_clear_beat_sat", 64'(out_s[out_s.size()-1]), 64'd1);

    for (int i = 0; i < 65540; i++) send(16'h4000, 8'd30);
    drain();
    chk("cnt_sticky", 64'(sat_count), 64'hFFFF);

    rdy_mode = 2;
    @(posedge clk); #1;
    base = out_d.size();
    send(16'h1234, 8'd0);
    send(16'h4321, 8'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("mid_rst_sat_count", 64'(sat_count), 64'd0);
    chk("mid_rst_up_ready", 64'(up_ready), 64'd1);
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_output", 64'(out_d.size() - base), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
